// File: rtl/mult_defs.sv
// Shared definitions for the sequential shift-add multiplier: state encodings
// and iteration count.
package mult_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int MULT_ITERS = 32;
    localparam int CNT_W      = 6;

endpackage

// File: rtl/seq_mult_32bit_if.sv
// Start/busy/done handshake bundle between a requester and the multiplier.
interface seq_mult_32bit_if;

    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] product;

    modport master (output start, mcand, mplier, input busy, done, product);
    modport slave  (input start, mcand, mplier, output busy, done, product);

endinterface

// File: rtl/cla_32bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with group carries
// chained between groups.
module cla_32bit (
    output logic [31:0] sum,
    output logic        cout,
    input  logic [31:0] ain,
    input  logic [31:0] bin,
    input  logic        cin
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    always_comb begin
        w_g = ain & bin;
        w_p = ain ^ bin;
        w_c = '0;
        w_c[0] = cin;
        for (int blk = 0; blk < 8; blk++) begin
            // Every carry inside a group is formed directly from the group carry-in.
            w_c[blk*4+1] = w_g[blk*4] | (w_p[blk*4] & w_c[blk*4]);
            w_c[blk*4+2] = w_g[blk*4+1]
                         | (w_p[blk*4+1] & w_g[blk*4])
                         | (w_p[blk*4+1] & w_p[blk*4] & w_c[blk*4]);
            w_c[blk*4+3] = w_g[blk*4+2]
                         | (w_p[blk*4+2] & w_g[blk*4+1])
                         | (w_p[blk*4+2] & w_p[blk*4+1] & w_g[blk*4])
                         | (w_p[blk*4+2] & w_p[blk*4+1] & w_p[blk*4] & w_c[blk*4]);
            w_c[blk*4+4] = w_g[blk*4+3]
                         | (w_p[blk*4+3] & w_g[blk*4+2])
                         | (w_p[blk*4+3] & w_p[blk*4+2] & w_g[blk*4+1])
                         | (w_p[blk*4+3] & w_p[blk*4+2] & w_p[blk*4+1] & w_g[blk*4])
                         | ((&w_p[blk*4 +: 4]) & w_c[blk*4]);
        end
    end

    assign sum  = w_p ^ w_c[31:0];
    assign cout = w_c[32];

endmodule

// File: rtl/seq_mult_32bit.sv
// Sequential unsigned 32x32 -> 64 shift-add multiplier; one partial-product
// add per clock through a single shared cla_32bit.
module seq_mult_32bit
    import mult_defs::*;
(
    input  logic               clk,
    input  logic               rst,
    seq_mult_32bit_if.slave    bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mcand;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [31:0]      w_bin;
    logic [31:0]      w_sum;
    logic             w_cout;

    assign w_bin = r_lo[0] ? r_mcand : 32'd0;

    cla_32bit u_cla (
        .sum  (w_sum),
        .cout (w_cout),
        .ain  (r_hi),
        .bin  (w_bin),
        .cin  (1'b0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_mcand <= bus.mcand;
                        r_hi    <= '0;
                        r_lo    <= bus.mplier;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Carry-out is kept as bit 64 of the shifted partial product.
                    {r_hi, r_lo} <= {w_cout, w_sum, r_lo[31:1]};
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(MULT_ITERS - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = (r_state == S_RUN);
    assign bus.done    = (r_state == S_DONE);
    assign bus.product = {r_hi, r_lo};

endmodule

// File: doc/seq_mult_32bit.md
# seq_mult_32bit

Sequential unsigned 32x32 -> 64-bit shift-add multiplier controller. It owns one shared `cla_32bit` adder and sequences it over 32 iterations, one partial-product add per clock. It sits beside the ALU as the multi-cycle multiply unit and uses a start/busy/done handshake.

## Interface
- Parameters: none. Width is fixed at 32 by the adder; the iteration count is a package constant.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `start`  in  1  request a multiply; sampled on the rising edge.
- `mcand`  in  32  multiplicand, unsigned; captured when `start` is accepted.
- `mplier`  in  32  multiplier, unsigned; captured when `start` is accepted.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle on.
- `product`  out  64  result register; holds its value until the next accepted `start` or `rst`.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: 32 iterations.
  - DONE: one cycle, `done`=1.
- Registers:
  - `mcand_r` [31:0]
  - `hi` [31:0]
  - `lo` [31:0]
  - iteration counter `cnt` [5:0]
  - `product` = {`hi`,`lo`}
- Accept: `start`=1 in IDLE or DONE.
  - Load `mcand_r`<=`mcand`, `hi`<=0, `lo`<=`mplier`, `cnt`<=0.
  - Go to RUN.
- `start` in RUN is ignored. The operands are not re-sampled and the operation continues.
- RUN iteration, each edge:
  - Adder inputs: `ain`=`hi`, `bin`=`lo[0]` ? `mcand_r` : 0, `cin`=0.
  - {`hi`,`lo`} <= {`cout`,`sum`,`lo`[31:1]}, which is a 65-bit value shifted right by 1.
  - `cnt` <= `cnt`+1.
  - When `cnt`==31 at the edge, go to DONE.
- DONE:
  - `start`=1 goes to RUN with a fresh load.
  - Otherwise go to IDLE.
- Arithmetic is unsigned only. The carry-out of every add is retained, so a 64-bit overflow is impossible.
- Adder carry-out outside RUN is don't-care.
- Outputs are decoded from state: `busy`=(state==RUN), `done`=(state==DONE).

## Timing
- Reset (edge with `rst`=1):
  - state=IDLE, `busy`=0, `done`=0, `product`=0, `cnt`=0, `mcand_r`=0.
  - Reset has priority over `start` on the same edge.
- Reset mid-RUN aborts the operation: no `done` pulse, `product`=0 after the edge.
- Accept edge E0: `busy`=1 from just after E0.
- Iterations occur on edges E1..E32.
- After E32: `busy`=0, `done`=1 for exactly one cycle, and `product` is final.
- Latency is 33 clocks from the accept edge to `done` high.
- Throughput with `start` held or re-asserted in DONE: one result per 33 clocks.
- `product` holds constant in IDLE. Intermediate values are visible during RUN but are not valid.
- The adder path (hi + mcand_r through `cla_32bit`, then the mux, then the register) is the single critical path. There is no other combinational path from input to output.

## Structure
- Shared package/header `mult_defs`:
  - state encodings S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10
  - MULT_ITERS=32
- Sub-module: one instance of the team's `cla_32bit` adder (sum, cout, ain, bin, cin). It is the only arithmetic in the block.
- Remaining RUN logic, all in this module:
  - the operand AND-mux
  - the shift register
  - the counter
  - the FSM

## Test plan
- Basic product: `mcand`=3, `mplier`=5, pulse `start` -> `done` 33 clocks later, `product`=64'h0000_0000_0000_000F, `busy` high for exactly 32 clocks.
- Max operands: `mcand`=`mplier`=32'hFFFF_FFFF -> `product`=64'hFFFF_FFFE_0000_0001. This checks that the carry-out is retained on every add.
- Zero operand: `mcand`=32'h1234_5678, `mplier`=0 -> `product`=0. Second run with the operands swapped -> also 0.
- Start while busy: start 7*9, then at cycle 10 assert `start` with 2*2 -> exactly one `done`, `product`=63; the second request is ignored.
- Back-to-back: hold `start`=1 with 0x10000*0x10000 followed by 6*7 -> `done` pulses at +33 and +66, products 64'h0000_0001_0000_0000 then 42, `busy` low only during the DONE cycles.
- Reset mid-op: assert `rst` at iteration 15 of 0xFFFF_FFFF*2 -> next cycle `busy`=0, `done`=0, `product`=0, and no `done` pulse afterwards. Reset asserted together with `start` -> remains IDLE.
